sync_fifo_fwft: RTL and testbench

Single-clock, parametrised FIFO that generalises the team's FIFO to arbitrary (non-power-of-two) depth. It adds:

- a selectable first-word-fall-through (FWFT) read mode;
- programmable almost-full and almost-empty thresholds;
- a live occupancy count;
- sticky overflow and underflow error flags;
- a synchronous flush.

It sits between a producer and a consumer in the same clock domain, and is the standard buffering element for the address and data paths.

---
 rtl/sync_fifo_fwft_if.sv | 36 +++
 rtl/sync_fifo_fwft.sv | 124 ++++++++++++
 tb/tb_sync_fifo_fwft.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_fwft_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_fwft.
// master drives requests; slave is the FIFO side.
interface sync_fifo_fwft_if #(
   parameter int DATA_BITS   = 11,
   parameter int FIFO_LENGTH = 16
);
   localparam int LW = $clog2(FIFO_LENGTH + 1);

   logic                 flush;
   logic                 wr_en;
   logic [DATA_BITS-1:0] wr_data;
   logic                 rd_en;
   logic [DATA_BITS-1:0] rd_data;
   logic                 rd_valid;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [LW-1:0]        level;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output flush, wr_en, wr_data, rd_en,
      input  rd_data, rd_valid, full, empty,
      input  almost_full, almost_empty, level,
      input  overflow, underflow
   );

   modport slave (
      input  flush, wr_en, wr_data, rd_en,
      output rd_data, rd_valid, full, empty,
      output almost_full, almost_empty, level,
      output overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO of arbitrary depth with optional first-word-fall-through,
// threshold flags, occupancy count, sticky error flags and synchronous flush.
module sync_fifo_fwft #(
   parameter int DATA_BITS     = 11,
   parameter int FIFO_LENGTH   = 16,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = FIFO_LENGTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input logic             clk,
   input logic             reset,
   sync_fifo_fwft_if.slave bus
);
   localparam int LW = $clog2(FIFO_LENGTH + 1);
   localparam int PW = $clog2(FIFO_LENGTH);
   localparam logic [PW-1:0] P_LAST = PW'(FIFO_LENGTH - 1);
   localparam logic [LW-1:0] L_FULL = LW'(FIFO_LENGTH);
   localparam logic [LW-1:0] L_AF   = LW'(AFULL_THRESH);
   localparam logic [LW-1:0] L_AE   = LW'(AEMPTY_THRESH);

   logic [DATA_BITS-1:0] r_mem [FIFO_LENGTH];
   logic [PW-1:0]        r_wptr;
   logic [PW-1:0]        r_rptr;
   logic [LW-1:0]        r_level;
   logic                 r_full;
   logic                 r_empty;
   logic                 r_afull;
   logic                 r_aempty;
   logic                 r_ovf;
   logic                 r_unf;

   logic                 w_wr_acc;
   logic                 w_rd_acc;
   logic [LW-1:0]        w_level_nxt;

   assign w_wr_acc = bus.wr_en && !r_full && !bus.flush;
   assign w_rd_acc = bus.rd_en && !r_empty && !bus.flush;

   always_comb begin
      w_level_nxt = r_level;
      if (bus.flush)
         w_level_nxt = '0;
      else if (w_wr_acc && !w_rd_acc)
         w_level_nxt = r_level + 1'b1;
      else if (w_rd_acc && !w_wr_acc)
         w_level_nxt = r_level - 1'b1;
   end

   // Storage is deliberately not reset; contents are meaningless after reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc)
         r_mem[r_wptr] <= bus.wr_data;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr   <= '0;
         r_rptr   <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_afull  <= (AFULL_THRESH == 0);
         r_aempty <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
         end else begin
            if (w_wr_acc)
               r_wptr <= (r_wptr == P_LAST) ? '0 : r_wptr + 1'b1;
            if (w_rd_acc)
               r_rptr <= (r_rptr == P_LAST) ? '0 : r_rptr + 1'b1;
         end
         r_level  <= w_level_nxt;
         r_full   <= (w_level_nxt == L_FULL);
         r_empty  <= (w_level_nxt == '0);
         r_afull  <= (w_level_nxt >= L_AF);
         r_aempty <= (w_level_nxt <= L_AE);
         if (bus.flush)
            r_ovf <= 1'b0;
         else if (bus.wr_en && r_full)
            r_ovf <= 1'b1;
         if (bus.flush)
            r_unf <= 1'b0;
         else if (bus.rd_en && r_empty)
            r_unf <= 1'b1;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is shown straight from the array at the read pointer.
         assign bus.rd_valid = !r_empty;
         assign bus.rd_data  = r_empty ? '0 : r_mem[r_rptr];
      end else begin : g_std
         logic [DATA_BITS-1:0] r_rd_data;
         logic                 r_rd_valid;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc)
                  r_rd_data <= r_mem[r_rptr];
            end
         end

         assign bus.rd_valid = r_rd_valid;
         assign bus.rd_data  = r_rd_data;
      end
   endgenerate

   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_afull;
   assign bus.almost_empty = r_aempty;
   assign bus.level        = r_level;
   assign bus.overflow     = r_ovf;
   assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: standard depth-16, standard depth-12
// and FWFT depth-16 instances share one clock and reset.
module tb_sync_fifo_fwft;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   sync_fifo_fwft_if #(.DATA_BITS(11), .FIFO_LENGTH(16)) a_if ();
   sync_fifo_fwft_if #(.DATA_BITS(11), .FIFO_LENGTH(12)) b_if ();
   sync_fifo_fwft_if #(.DATA_BITS(11), .FIFO_LENGTH(16)) c_if ();

   sync_fifo_fwft #(
      .DATA_BITS(11), .FIFO_LENGTH(16), .FWFT(0),
      .AFULL_THRESH(14), .AEMPTY_THRESH(2)
   ) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));

   sync_fifo_fwft #(
      .DATA_BITS(11), .FIFO_LENGTH(12), .FWFT(0),
      .AFULL_THRESH(10), .AEMPTY_THRESH(2)
   ) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));

   sync_fifo_fwft #(
      .DATA_BITS(11), .FIFO_LENGTH(16), .FWFT(1),
      .AFULL_THRESH(14), .AEMPTY_THRESH(2)
   ) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #12;
      tests++;
      if ({a_if.level, a_if.empty, a_if.full, a_if.almost_empty,
           a_if.almost_full, a_if.rd_valid, a_if.rd_data,
           a_if.overflow, a_if.underflow}
          !== {5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_a got lvl=%0d e=%b f=%b ae=%b af=%b v=%b d=%0d exp 0 1 0 1 0 0 0",
                  a_if.level, a_if.empty, a_if.full, a_if.almost_empty,
                  a_if.almost_full, a_if.rd_valid, a_if.rd_data);
      end
      tests++;
      if ({b_if.level, b_if.empty, b_if.full, b_if.almost_empty,
           b_if.almost_full, b_if.rd_valid, b_if.rd_data,
           b_if.overflow, b_if.underflow}
          !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_b got lvl=%0d e=%b f=%b v=%b exp 0 1 0 0",
                  b_if.level, b_if.empty, b_if.full, b_if.rd_valid);
      end
      tests++;
      if ({c_if.level, c_if.empty, c_if.rd_valid, c_if.rd_data,
           c_if.overflow, c_if.underflow}
          !== {5'd0, 1'b1, 1'b0, 11'd0, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_c got lvl=%0d e=%b v=%b d=%0d exp 0 1 0 0",
                  c_if.level, c_if.empty, c_if.rd_valid, c_if.rd_data);
      end
      @(negedge clk);
      reset = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      for (int i = 0; i < 10; i++) begin
         a_if.wr_en   = 1'b1;
         a_if.wr_data = 11'(i);
         tick();
         tests++;
         if ({a_if.level, a_if.empty} !== {5'(i + 1), 1'b0}) begin
            fails++;
            $display("FAIL basic_wr i=%0d got lvl=%0d e=%b exp lvl=%0d e=0",
                     i, a_if.level, a_if.empty, i + 1);
         end
      end
      a_if.wr_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a_if.rd_en = 1'b1;
         tick();
         tests++;
         if ({a_if.rd_valid, a_if.rd_data, a_if.level}
             !== {1'b1, 11'(i), 5'(9 - i)}) begin
            fails++;
            $display("FAIL basic_rd i=%0d got v=%b d=%0d lvl=%0d exp 1 %0d %0d",
                     i, a_if.rd_valid, a_if.rd_data, a_if.level, i, 9 - i);
         end
      end
      a_if.rd_en = 1'b0;
      tick();
      tests++;
      if ({a_if.rd_valid, a_if.rd_data, a_if.empty}
          !== {1'b0, 11'd9, 1'b1}) begin
         fails++;
         $display("FAIL basic_idle got v=%b d=%0d e=%b exp 0 9 1",
                  a_if.rd_valid, a_if.rd_data, a_if.empty);
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 12; i++) begin
         b_if.wr_en   = 1'b1;
         b_if.wr_data = 11'(i);
         tick();
         tests++;
         if (b_if.full !== (i == 11)) begin
            fails++;
            $display("FAIL ovf_full i=%0d got %b exp %b",
                     i, b_if.full, (i == 11));
         end
      end
      b_if.wr_data = 11'd99;
      tick();
      b_if.wr_en = 1'b0;
      tests++;
      if ({b_if.full, b_if.overflow, b_if.level}
          !== {1'b1, 1'b1, 4'd12}) begin
         fails++;
         $display("FAIL ovf_set got f=%b o=%b lvl=%0d exp 1 1 12",
                  b_if.full, b_if.overflow, b_if.level);
      end
      for (int i = 0; i < 12; i++) begin
         b_if.rd_en = 1'b1;
         tick();
         tests++;
         if ({b_if.rd_valid, b_if.rd_data, b_if.overflow}
             !== {1'b1, 11'(i), 1'b1}) begin
            fails++;
            $display("FAIL ovf_rd i=%0d got v=%b d=%0d o=%b exp 1 %0d 1",
                     i, b_if.rd_valid, b_if.rd_data, b_if.overflow, i);
         end
      end
      b_if.rd_en = 1'b0;
      tick();
      tests++;
      if ({b_if.empty, b_if.overflow} !== 2'b11) begin
         fails++;
         $display("FAIL ovf_sticky got e=%b o=%b exp 1 1",
                  b_if.empty, b_if.overflow);
      end
      b_if.flush = 1'b1;
      tick();
      b_if.flush = 1'b0;
      tests++;
      if (b_if.overflow !== 1'b0) begin
         fails++;
         $display("FAIL ovf_flush got %b exp 0", b_if.overflow);
      end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 8; i++) begin
         b_if.wr_en   = 1'b1;
         b_if.wr_data = 11'(200 + i);
         tick();
      end
      b_if.wr_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         b_if.rd_en = 1'b1;
         tick();
         tests++;
         if ({b_if.rd_valid, b_if.rd_data} !== {1'b1, 11'(200 + i)}) begin
            fails++;
            $display("FAIL wrap_pre i=%0d got v=%b d=%0d exp 1 %0d",
                     i, b_if.rd_valid, b_if.rd_data, 200 + i);
         end
      end
      for (int k = 0; k <= 20; k++) begin
         b_if.wr_en   = (k < 20);
         b_if.wr_data = 11'(100 + k);
         b_if.rd_en   = (k >= 1);
         tick();
         tests++;
         if ({b_if.rd_valid, b_if.level}
             !== {(k >= 1), ((k < 20) ? 4'd1 : 4'd0)}) begin
            fails++;
            $display("FAIL wrap_lvl k=%0d got v=%b lvl=%0d exp %b %0d",
                     k, b_if.rd_valid, b_if.level, (k >= 1), (k < 20));
         end
         if (k >= 1) begin
            tests++;
            if (b_if.rd_data !== 11'(99 + k)) begin
               fails++;
               $display("FAIL wrap_data k=%0d got %0d exp %0d",
                        k, b_if.rd_data, 99 + k);
            end
         end
      end
      b_if.wr_en = 1'b0;
      b_if.rd_en = 1'b0;
      tests++;
      if ({b_if.empty, b_if.underflow} !== 2'b10) begin
         fails++;
         $display("FAIL wrap_end got e=%b u=%b exp 1 0",
                  b_if.empty, b_if.underflow);
      end
   endtask

   task automatic test_fwft;
      c_if.wr_en   = 1'b1;
      c_if.wr_data = 11'h55;
      tick();
      c_if.wr_en = 1'b0;
      tests++;
      if ({c_if.rd_valid, c_if.rd_data, c_if.level}
          !== {1'b1, 11'h55, 5'd1}) begin
         fails++;
         $display("FAIL fwft_first got v=%b d=%0h lvl=%0d exp 1 55 1",
                  c_if.rd_valid, c_if.rd_data, c_if.level);
      end
      tick();
      tests++;
      if ({c_if.rd_valid, c_if.rd_data} !== {1'b1, 11'h55}) begin
         fails++;
         $display("FAIL fwft_hold got v=%b d=%0h exp 1 55",
                  c_if.rd_valid, c_if.rd_data);
      end
      c_if.wr_en   = 1'b1;
      c_if.wr_data = 11'h66;
      c_if.rd_en   = 1'b1;
      tick();
      c_if.wr_en = 1'b0;
      tests++;
      if ({c_if.rd_valid, c_if.rd_data, c_if.level}
          !== {1'b1, 11'h66, 5'd1}) begin
         fails++;
         $display("FAIL fwft_pop got v=%b d=%0h lvl=%0d exp 1 66 1",
                  c_if.rd_valid, c_if.rd_data, c_if.level);
      end
      tick();
      c_if.rd_en = 1'b0;
      tests++;
      if ({c_if.rd_valid, c_if.empty} !== 2'b01) begin
         fails++;
         $display("FAIL fwft_drain got v=%b e=%b exp 0 1",
                  c_if.rd_valid, c_if.empty);
      end
   endtask

   task automatic test_thresholds;
      int lvl;
      for (int i = 0; i < 16; i++) begin
         a_if.wr_en   = 1'b1;
         a_if.wr_data = 11'(300 + i);
         tick();
         lvl = i + 1;
         tests++;
         if ({a_if.almost_empty, a_if.almost_full, a_if.full, a_if.level}
             !== {(lvl <= 2), (lvl >= 14), (lvl == 16), 5'(lvl)}) begin
            fails++;
            $display("FAIL thr lvl=%0d got ae=%b af=%b f=%b l=%0d",
                     lvl, a_if.almost_empty, a_if.almost_full,
                     a_if.full, a_if.level);
         end
      end
      a_if.wr_data = 11'd999;
      tick();
      a_if.wr_en = 1'b0;
      tests++;
      if ({a_if.overflow, a_if.level} !== {1'b1, 5'd16}) begin
         fails++;
         $display("FAIL thr_ovf got o=%b lvl=%0d exp 1 16",
                  a_if.overflow, a_if.level);
      end
      for (int i = 0; i < 11; i++) begin
         a_if.rd_en = 1'b1;
         tick();
         tests++;
         if ({a_if.rd_data, a_if.level} !== {11'(300 + i), 5'(15 - i)}) begin
            fails++;
            $display("FAIL thr_rd i=%0d got d=%0d lvl=%0d exp %0d %0d",
                     i, a_if.rd_data, a_if.level, 300 + i, 15 - i);
         end
      end
      a_if.rd_en = 1'b0;
      tick();
   endtask

   task automatic test_flush;
      a_if.flush   = 1'b1;
      a_if.wr_en   = 1'b1;
      a_if.wr_data = 11'd500;
      a_if.rd_en   = 1'b1;
      tick();
      a_if.flush = 1'b0;
      a_if.wr_en = 1'b0;
      a_if.rd_en = 1'b0;
      tests++;
      if ({a_if.level, a_if.empty, a_if.full, a_if.overflow,
           a_if.rd_valid, a_if.rd_data}
          !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd310}) begin
         fails++;
         $display("FAIL flush got lvl=%0d e=%b f=%b o=%b v=%b d=%0d exp 0 1 0 0 0 310",
                  a_if.level, a_if.empty, a_if.full, a_if.overflow,
                  a_if.rd_valid, a_if.rd_data);
      end
      tick();
      tests++;
      if ({a_if.level, a_if.empty} !== {5'd0, 1'b1}) begin
         fails++;
         $display("FAIL flush_wr_ignored got lvl=%0d e=%b exp 0 1",
                  a_if.level, a_if.empty);
      end
      a_if.rd_en = 1'b1;
      tick();
      a_if.rd_en = 1'b0;
      tests++;
      if ({a_if.underflow, a_if.rd_valid, a_if.level}
          !== {1'b1, 1'b0, 5'd0}) begin
         fails++;
         $display("FAIL unf_set got u=%b v=%b lvl=%0d exp 1 0 0",
                  a_if.underflow, a_if.rd_valid, a_if.level);
      end
      tick();
      tests++;
      if (a_if.underflow !== 1'b1) begin
         fails++;
         $display("FAIL unf_sticky got %b exp 1", a_if.underflow);
      end
   endtask

   task automatic test_async_reset;
      for (int i = 1; i <= 3; i++) begin
         a_if.wr_en   = 1'b1;
         a_if.wr_data = 11'(i);
         c_if.wr_en   = 1'b1;
         c_if.wr_data = 11'h77;
         tick();
      end
      a_if.wr_en = 1'b0;
      c_if.wr_en = 1'b0;
      tests++;
      if ({a_if.level, c_if.rd_valid, c_if.rd_data}
          !== {5'd3, 1'b1, 11'h77}) begin
         fails++;
         $display("FAIL areset_pre got lvl=%0d cv=%b cd=%0h exp 3 1 77",
                  a_if.level, c_if.rd_valid, c_if.rd_data);
      end
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      tests++;
      if ({a_if.level, a_if.empty, a_if.almost_empty, a_if.rd_data,
           a_if.underflow}
          !== {5'd0, 1'b1, 1'b1, 11'd0, 1'b0}) begin
         fails++;
         $display("FAIL areset_a got lvl=%0d e=%b ae=%b d=%0d u=%b exp 0 1 1 0 0",
                  a_if.level, a_if.empty, a_if.almost_empty,
                  a_if.rd_data, a_if.underflow);
      end
      tests++;
      if ({c_if.level, c_if.rd_valid, c_if.rd_data, c_if.empty}
          !== {5'd0, 1'b0, 11'd0, 1'b1}) begin
         fails++;
         $display("FAIL areset_c got lvl=%0d v=%b d=%0h e=%b exp 0 0 0 1",
                  c_if.level, c_if.rd_valid, c_if.rd_data, c_if.empty);
      end
      #10;
      @(negedge clk);
      reset = 1'b1;
      tick();
      tests++;
      if ({a_if.level, a_if.empty} !== {5'd0, 1'b1}) begin
         fails++;
         $display("FAIL areset_release got lvl=%0d e=%b exp 0 1",
                  a_if.level, a_if.empty);
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      a_if.flush = 1'b0; a_if.wr_en = 1'b0;
      a_if.rd_en = 1'b0; a_if.wr_data = '0;
      b_if.flush = 1'b0; b_if.wr_en = 1'b0;
      b_if.rd_en = 1'b0; b_if.wr_data = '0;
      c_if.flush = 1'b0; c_if.wr_en = 1'b0;
      c_if.rd_en = 1'b0; c_if.wr_data = '0;
      test_reset();
      test_basic();
      test_overflow();
      test_wrap();
      test_fwft();
      test_thresholds();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
